// File: rtl/asteroids_pkg.sv
// Shared types and constants for the pixel-write path between drawers and the VGA adapter.
package asteroids_pkg;

    localparam int COORD_W   = 10;
    localparam int COLOR_W   = 3;
    localparam int H_RES_DEF = 320;
    localparam int V_RES_DEF = 240;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr, wrapping modulo N.
module rr_pick
    import asteroids_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    always_comb begin
        logic [IDX_W-1:0] cand;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/plot_arbiter.sv
// Round-robin, burst-locked arbiter sharing the VGA adapter pixel-write port among drawers.
//   state | meaning
//   IDLE  | no owner; any pending request is arbitrated this cycle
//   BUSY  | owner holds the port until its last beat or forced release
module plot_arbiter
    import asteroids_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int H_RES     = H_RES_DEF,
    parameter int V_RES     = V_RES_DEF,
    parameter int MAX_BURST = 1024
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ-1:0]         last,
    input  logic [NUM_REQ*COORD_W-1:0] req_x,
    input  logic [NUM_REQ*COORD_W-1:0] req_y,
    input  logic [NUM_REQ*COLOR_W-1:0] req_color,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [COORD_W-1:0]         x,
    output logic [COORD_W-1:0]         y,
    output logic [COLOR_W-1:0]         color,
    output logic                       plot,
    output logic                       busy,
    output logic                       burst_overflow
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [CNT_W-1:0]   CNT_SAT  = CNT_W'(MAX_BURST);
    localparam logic [COORD_W-1:0] X_LIM    = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0] Y_LIM    = COORD_W'(V_RES);
    localparam logic [IDX_W-1:0]   PTR_RST  = IDX_W'(NUM_REQ - 1);

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_d;
    pixel_t             pix_q, pix_d, owner_pix;
    logic               plot_d;
    logic               ovf_d;

    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               any_req;

    logic accept;
    logic at_limit;
    logic forced;
    logic release_beat;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (win_onehot),
        .idx    (win_idx),
        .any    (any_req)
    );

    always_comb begin
        owner_pix = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                owner_pix.x     = req_x[i*COORD_W +: COORD_W];
                owner_pix.y     = req_y[i*COORD_W +: COORD_W];
                owner_pix.color = req_color[i*COLOR_W +: COLOR_W];
            end
        end
    end

    // A beat at the count limit without last is still plotted, then the port is released.
    assign accept       = (state_q == BUSY) && req[owner_q];
    assign at_limit     = (cnt_q >= CNT_LAST);
    assign forced       = accept && !last[owner_q] && at_limit;
    assign release_beat = accept && (last[owner_q] || at_limit);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            ptr_q          <= PTR_RST;
            owner_q        <= '0;
            cnt_q          <= '0;
            gnt            <= '0;
            pix_q          <= '0;
            plot           <= 1'b0;
            burst_overflow <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            owner_q        <= owner_d;
            cnt_q          <= cnt_d;
            gnt            <= gnt_d;
            pix_q          <= pix_d;
            plot           <= plot_d;
            burst_overflow <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req) state_d = BUSY;
            BUSY:    if (release_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d   = gnt;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        pix_d   = pix_q;
        plot_d  = 1'b0;
        ovf_d   = burst_overflow | forced;
        if (state_q == IDLE && any_req) begin
            gnt_d   = win_onehot;
            owner_d = win_idx;
            cnt_d   = '0;
        end
        if (accept) begin
            pix_d  = owner_pix;
            plot_d = (owner_pix.x < X_LIM) && (owner_pix.y < Y_LIM);
            if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
        if (release_beat) begin
            gnt_d = '0;
            ptr_d = owner_q;
        end
    end

    assign x     = pix_q.x;
    assign y     = pix_q.y;
    assign color = pix_q.color;
    assign busy  = (state_q == BUSY);

endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
Shares the single pixel-write port of the VGA adapter (x, y, colour, plot) between NUM_REQ drawing requesters. Requesters include the ship, asteroid and shot drawers and the screen-clear/erase engine. Arbitration is round-robin and burst-locked: a granted requester keeps the port until it signals the last pixel of its burst. The block sits between the per-entity drawers and the vga_adapter instance in the top level.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
H_RES, 320, horizontal resolution; beats with x >= H_RES are clipped
V_RES, 240, vertical resolution; beats with y >= V_RES are clipped
MAX_BURST, 1024, accepted beats after which a burst with no last is forcibly released

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset_n  in  1  asynchronous, active-low reset
req  in  NUM_REQ  per-requester beat valid
last  in  NUM_REQ  marks the final beat of a burst; qualified by req
req_x  in  NUM_REQ*10  packed x coordinates; requester i uses bits [10i+9:10i]
req_y  in  NUM_REQ*10  packed y coordinates, same packing as req_x
req_color  in  NUM_REQ*3  packed 3-bit colours
gnt  out  NUM_REQ  one-hot grant, registered
x  out  10  pixel x to the adapter, registered
y  out  10  pixel y to the adapter, registered
color  out  3  pixel colour to the adapter, registered
plot  out  1  write strobe to the adapter, registered
busy  out  1  high while state is BUSY
burst_overflow  out  1  sticky; set when a burst is forcibly released

Behaviour:
- Reset (asynchronous, while reset_n=0):
  - gnt, x, y, color, plot, busy and burst_overflow = 0.
  - state = IDLE, rr pointer = NUM_REQ-1 (so requester 0 wins first), beat count = 0.
- State IDLE:
  - If any req is high, the winner is the first set req scanning from pointer+1 upward, wrapping modulo NUM_REQ.
  - Next edge: gnt[winner]=1, state=BUSY, owner=winner, beat count=0.
  - If no req is high, stay in IDLE.
  - last and coordinate inputs are ignored in IDLE.
- State BUSY:
  - A beat is accepted on an edge where req[owner]=1. Handshake: gnt acts as ready, req as valid.
  - req[owner]=0: stall. Grant is held, plot=0 on the next cycle, and no other requester is served (burst lock).
  - Requests from non-owners are ignored and must hold until granted.
- Accepted beat:
  - Next edge: x/y/color take the owner's slice.
  - plot=1 only if x<H_RES and y<V_RES; a clipped beat is still accepted, with plot=0.
  - plot is a single-cycle pulse per accepted beat; plot=0 on every edge with no accepted beat.
  - x/y/color hold their last values when no beat is accepted.
- Burst end:
  - An accepted beat with last[owner]=1 sets, on the same edge: gnt=0, state=IDLE, pointer=owner.
  - Minimum gap between bursts is 1 idle cycle, used for arbitration.
- Forced release:
  - If beat count reaches MAX_BURST-1 and another beat without last is accepted, that beat is plotted normally and release happens as for last.
  - burst_overflow is also set and stays set until reset.
- Latency: req rises in IDLE at cycle 0 -> gnt at cycle 1 -> first beat accepted at the end of cycle 1 -> plot at cycle 2. Sustained throughput is 1 pixel/cycle within a burst.
- A single-beat burst (req and last together) is legal: gnt lasts exactly 1 cycle.
- Beat count: $clog2(MAX_BURST+1) bits, saturating, cleared on grant.

Decomposition:
- asteroids_pkg:
  - COORD_W=10, COLOR_W=3, H_RES/V_RES defaults.
  - typedef pixel_t {x, y, color}.
  - typedef enum arb_state_t {IDLE, BUSY}.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector and pointer.
  - Outputs: one-hot winner and its index.
  - Instantiated once.

Test Plan:
- Reset mid-burst: hold reset_n=0 during a BUSY burst -> all outputs 0 immediately. After release, req[1] alone -> gnt=0010 one cycle later, state BUSY.
- Single requester: req[0] burst of 3 beats at (5,5),(6,5),(7,5) colour 3'b100, last on beat 3 -> plot high on 3 consecutive cycles starting 2 cycles after req; gnt falls the edge after beat 3.
- Round-robin: req[0] and req[2] held, each burst 2 beats -> grant order 0,2,0,2; req[2] is never starved; 1 idle cycle between bursts.
- Burst lock: owner 1 drops req for 4 cycles mid-burst while req[3] is high -> gnt stays 0010, plot=0 for those 4 cycles, req[3] is served only after last from requester 1.
- Clipping: beats at (319,239) and (320,10) -> first plotted; second accepted with plot=0 and x=320 on the output.
- Overflow: MAX_BURST=8, requester 2 streams 8 beats with no last -> 8 plots, gnt drops after beat 8, burst_overflow=1 and stays 1; next grant goes to requester 3 if requesting.
